seg_scroller: RTL and testbench
===============================

SEG_SCROLLER -- requirements
Module: seg_scroller

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed 7-segment digits, legal range 1..8.
REQ-002 Parameter SEQ_LEN, default 15: number of ROM symbols in the display sequence, legal range 2..16.
REQ-003 Parameter DIV_SLOW, default 50_000_000: clk cycles per scroll step in slow mode.
REQ-004 Parameter DIV_FAST, default 5_000_000: clk cycles per scroll step in fast mode.
REQ-005 Parameter DIV_SCAN, default 50_000: clk cycles each digit stays enabled during multiplexing.
REQ-006 clk  input  1  system clock, 50 MHz; the single clock of the block.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 sel  input  1  rate select: 0 selects DIV_SLOW, 1 selects DIV_FAST.
REQ-009 run  input  1  1 = auto-scroll, 0 = paused.
REQ-010 dir  input  1  0 = forward (index +1), 1 = reverse (index -1).
REQ-011 step  input  1  single-step request, synchronous to clk, honoured only while run=0.
REQ-012 seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-013 an  output  DIGITS  active-low digit enables, one-hot-low, registered; bit 0 is the leftmost digit.
REQ-014 pos  output  4  current sequence index, 0..SEQ_LEN-1.

Function
REQ-015 Sequence ROM entries 0..14 SHALL be hex 0,2,0,9,8,0,2,1,1,5,E,D,C,B,A; entries at or above SEQ_LEN SHALL never be addressed.
REQ-016 Rate counter SHALL count 0..DIV-1, with DIV chosen by sel; the cycle in which it equals DIV-1 is a tick, and the counter wraps to 0 on the following edge.
REQ-017 Any change of sel (detected against a registered copy of sel) SHALL clear the rate counter to 0 on that edge, with no tick in that cycle.
REQ-018 While run=0 the rate counter SHALL hold at 0 and ticks SHALL be suppressed.
REQ-019 A step event is a 0->1 transition of step, detected against a registered copy of step; it SHALL advance pos exactly once, and only while run=0.
REQ-020 Step events while run=1 SHALL be ignored; a step held high SHALL produce only one advance.
REQ-021 On each tick or accepted step, pos SHALL update on that edge: forward SEQ_LEN-1 -> 0; reverse 0 -> SEQ_LEN-1; otherwise +/-1 per dir.
REQ-022 A dir change SHALL take effect on the next advance without altering pos or the rate counter.
REQ-023 Scan counter SHALL count 0..DIV_SCAN-1; on its wrap, digit select d SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-024 Digit d SHALL display ROM[(pos + d) mod SEQ_LEN], so the window scrolls left in forward mode.
REQ-025 Each cycle, an and seg SHALL be registered together from the current d and pos (one-cycle latency): an = all ones except bit d = 0; seg = hex decode of the selected symbol.
REQ-026 Hex decode, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
REQ-027 A pos change SHALL be visible on seg within one clk cycle, with no digit skipped or doubled in the scan order.

Reset
REQ-028 While rst=1: pos=0, rate and scan counters=0, d=0, an=all ones, seg=1111111, and the registered sel/step copies take the current input values.
REQ-029 Reset asserted mid-scroll or mid-scan SHALL return all state to the REQ-028 values immediately, without waiting for clk.
REQ-030 On the first edge after rst falls, an SHALL become all ones except bit 0 = 0, and seg SHALL show digit 0's symbol (hex 0).

Verification (bench parameters DIV_SLOW=10, DIV_FAST=2, DIV_SCAN=3, DIGITS=4, SEQ_LEN=15)
REQ-031 Reset release, sel=0, run=1, dir=0 -> pos reads 1 after 10 cycles and 14 after 140; on the next tick it wraps to 0.
REQ-032 run=1, dir=1, from pos=0 -> on the next tick pos=14, then 13; an rotates 1110,1101,1011,0111 every 3 cycles.
REQ-033 With pos=3 -> digits 0..3 show 9,8,0,2: seg values 0010000, 0000000, 1000000, 0100100.
REQ-034 run=0, step pulsed 3 times, step held high for 20 cycles -> pos advances by exactly 4 and no ticks occur; a step pulse with run=1 -> no extra advance.
REQ-035 sel toggled 0->1 when the rate counter reads 7 -> counter clears, next advance comes 2 cycles later, then every 2 cycles.
REQ-036 rst asserted between clk edges at pos=9 -> pos=0, an=1111, seg=1111111 immediately, before the next clk edge.

Source files
------------

// File: rtl/seg_scroller.sv
// Scrolling 7-segment message display: steps a fixed symbol sequence through a
// window of DIGITS multiplexed digits, auto-scrolled at two rates or single-stepped.
module seg_scroller #(
  parameter int DIGITS   = 4,
  parameter int SEQ_LEN  = 15,
  parameter int DIV_SLOW = 50_000_000,
  parameter int DIV_FAST = 5_000_000,
  parameter int DIV_SCAN = 50_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              run,
  input  logic              dir,
  input  logic              step,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic [3:0]        pos
);

  localparam int RATE_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int RW       = (RATE_MAX > 1) ? $clog2(RATE_MAX) : 1;
  localparam int SW       = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
  localparam int DW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [3:0]    LAST_POS   = 4'(SEQ_LEN - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(DIV_SCAN - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

  logic [RW-1:0]     rate_cnt;
  logic [RW-1:0]     rate_last;
  logic [SW-1:0]     scan_cnt;
  logic [DW-1:0]     d;
  logic              sel_q;
  logic              step_q;
  logic              sel_chg;
  logic              tick;
  logic              step_evt;
  logic              advance;
  logic              scan_wrap;
  logic [3:0]        pos_next;
  logic [DIGITS-1:0] an_next;
  logic [6:0]        seg_next;

  function automatic logic [3:0] rom_sym(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'h0;
      4'd1:    return 4'h2;
      4'd2:    return 4'h0;
      4'd3:    return 4'h9;
      4'd4:    return 4'h8;
      4'd5:    return 4'h0;
      4'd6:    return 4'h2;
      4'd7:    return 4'h1;
      4'd8:    return 4'h1;
      4'd9:    return 4'h5;
      4'd10:   return 4'hE;
      4'd11:   return 4'hD;
      4'd12:   return 4'hC;
      4'd13:   return 4'hB;
      4'd14:   return 4'hA;
      default: return 4'h0;
    endcase
  endfunction

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [3:0] window_idx(input logic [3:0] p, input logic [DW-1:0] dd);
    logic [4:0] sum;
    sum = 5'(p) + 5'(dd);
    return 4'(sum % 5'(SEQ_LEN));
  endfunction

  assign rate_last = sel ? RW'(DIV_FAST - 1) : RW'(DIV_SLOW - 1);
  assign sel_chg   = sel ^ sel_q;
  assign tick      = run & ~sel_chg & (rate_cnt == rate_last);
  assign step_evt  = step & ~step_q & ~run;
  assign advance   = tick | step_evt;
  assign scan_wrap = (scan_cnt == SCAN_LAST);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pos_next = pos;
    if (advance) begin
      if (dir) pos_next = (pos == 4'd0) ? LAST_POS : pos - 4'd1;
      else     pos_next = (pos == LAST_POS) ? 4'd0 : pos + 4'd1;
    end
  end

  always_comb begin
    an_next = '1;
    for (int i = 0; i < DIGITS; i++) an_next[i] = (d != DW'(i));
    seg_next = hex7(rom_sym(window_idx(pos, d)));
  end

  // NOTE: the edge-detect copies have no reset branch; they simply follow their inputs on
  // every clk edge, including while rst is held, so no false edge appears at release.
  always_ff @(posedge clk) begin
    sel_q  <= sel;
    step_q <= step;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update in parallel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_cnt <= '0;
      scan_cnt <= '0;
      d        <= '0;
      pos      <= 4'd0;
      an       <= '1;
      seg      <= 7'h7F;
    end else begin
      if (!run || sel_chg || tick) rate_cnt <= '0;
      else                         rate_cnt <= rate_cnt + RW'(1);

      if (scan_wrap) begin
        scan_cnt <= '0;
        d        <= (d == DIGIT_LAST) ? '0 : d + DW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end

      pos <= pos_next;
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scroller.sv
// Self-checking bench for seg_scroller with short dividers; expected values are
// queued when stimulus is applied and popped when the DUT output is sampled.
module tb_seg_scroller;

  logic       clk = 1'b0;
  logic       rst, sel, run, dir, step;
  logic [6:0] seg;
  logic [3:0] an;
  logic [3:0] pos;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [6:0] exp_q[$];
  logic [6:0] e;

  localparam logic [6:0] SEG_AT_POS3 [4] = '{7'b0010000, 7'b0000000, 7'b1000000, 7'b0100100};

  seg_scroller #(
    .DIGITS(4), .SEQ_LEN(15), .DIV_SLOW(10), .DIV_FAST(2), .DIV_SCAN(3)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .run(run), .dir(dir), .step(step),
    .seg(seg), .an(an), .pos(pos)
  );

  always #5 clk = ~clk;

  // Counts clk edges since reset release; the scan position follows directly from it.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_pos(input string name, input int n);
    wait_cyc(n);
    e = exp_q.pop_front();
    total++;
    if ({3'b000, pos} !== e) begin
      bad++;
      $display("FAIL %s: pos got=%0d exp=%0d", name, pos, e);
    end
  endtask

  task automatic step_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      step = 1'b1; wait_cyc(1);
      step = 1'b0; wait_cyc(1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sel = 1'b0; run = 1'b1; dir = 1'b0; step = 1'b0;
    wait_cyc(2);
    total += 3;
    if (pos !== 4'd0)       begin bad++; $display("FAIL reset_pos: got=%0d exp=0", pos); end
    if (an !== 4'b1111)     begin bad++; $display("FAIL reset_an: got=%b exp=1111", an); end
    if (seg !== 7'b1111111) begin bad++; $display("FAIL reset_seg: got=%b exp=1111111", seg); end
  endtask

  task automatic test_forward;
    rst = 1'b0;
    wait_cyc(1);
    total += 2;
    if (an !== 4'b1110)     begin bad++; $display("FAIL first_an: got=%b exp=1110", an); end
    if (seg !== 7'b1000000) begin bad++; $display("FAIL first_seg: got=%b exp=1000000", seg); end
    exp_q.push_back(7'd1);  check_pos("fwd_10", 9);
    exp_q.push_back(7'd14); check_pos("fwd_140", 130);
    exp_q.push_back(7'd0);  check_pos("fwd_wrap", 10);
  endtask

  task automatic test_reverse;
    dir = 1'b1;
    exp_q.push_back(7'd0);  check_pos("dir_change_hold", 1);
    exp_q.push_back(7'd14); check_pos("rev_wrap", 9);
    exp_q.push_back(7'd13); check_pos("rev_13", 10);
    for (int i = 0; i < 12; i++) begin
      wait_cyc(1);
      exp_q.push_back(7'(4'b1111 & ~(4'b0001 << (((cyc - 1) / 3) % 4))));
      e = exp_q.pop_front();
      total++;
      if ({3'b000, an} !== e) begin
        bad++;
        $display("FAIL an_rotate[%0d]: got=%b exp=%b", i, an, e[3:0]);
      end
    end
  endtask

  task automatic test_step;
    dir = 1'b0; run = 1'b0;
    exp_q.push_back(7'd12); check_pos("paused_no_tick", 12);
    step_pulses(3);
    exp_q.push_back(7'd0);  check_pos("three_pulses", 0);
    step = 1'b1; wait_cyc(20); step = 1'b0;
    exp_q.push_back(7'd1);  check_pos("held_high", 1);
    run = 1'b1; step = 1'b1; wait_cyc(1);
    step = 1'b0; wait_cyc(1); run = 1'b0;
    exp_q.push_back(7'd1);  check_pos("step_while_run", 1);
    step_pulses(2);
    exp_q.push_back(7'd3);  check_pos("pos3", 0);
  endtask

  task automatic test_window;
    wait_cyc(1);
    for (int i = 0; i < 12; i++) begin
      wait_cyc(1);
      exp_q.push_back(SEG_AT_POS3[((cyc - 1) / 3) % 4]);
      e = exp_q.pop_front();
      total++;
      if (seg !== e) begin
        bad++;
        $display("FAIL window_seg[%0d]: got=%b exp=%b", i, seg, e);
      end
    end
  endtask

  task automatic test_rate_switch;
    run = 1'b1; sel = 1'b0;
    exp_q.push_back(7'd3); check_pos("count_to_7", 7);
    sel = 1'b1;
    exp_q.push_back(7'd3); check_pos("sel_clear_edge", 1);
    exp_q.push_back(7'd3); check_pos("sel_plus1", 1);
    exp_q.push_back(7'd4); check_pos("sel_plus2", 1);
    exp_q.push_back(7'd5); check_pos("fast_next", 2);
    exp_q.push_back(7'd6); check_pos("fast_next2", 2);
  endtask

  task automatic test_async_reset;
    run = 1'b0;
    step_pulses(3);
    exp_q.push_back(7'd9); check_pos("pos9", 0);
    #2 rst = 1'b1;
    #1;
    total += 3;
    if (pos !== 4'd0)       begin bad++; $display("FAIL async_pos: got=%0d exp=0", pos); end
    if (an !== 4'b1111)     begin bad++; $display("FAIL async_an: got=%b exp=1111", an); end
    if (seg !== 7'b1111111) begin bad++; $display("FAIL async_seg: got=%b exp=1111111", seg); end
    wait_cyc(2);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_step();
    test_window();
    test_rate_switch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
